// File: rtl/adc_sample_sequencer_if.sv
// Bundles the ADC sequencer's control, serial pins and result signals.
//   slave  : the sequencer side (takes en/start/clr_ovr/data_in, drives pins + results)
//   master : the controller/bench side
//   en_i      periodic sampling enable
//   start_i   single-shot request
//   clr_ovr_i clears the sticky overrun flag
//   data_in_i ADC serial data (already synchronised)
//   sclk_o    serial clock, idles high
//   cs_o      chip select, active-low
//   dato_o    last received data bits [11:0]
//   zeros_o   last received leading bits
//   listo_o   one-cycle strobe: dato/zeros/err_z updated this cycle
//   busy_o    frame in progress
//   err_z_o   last frame's leading bits were non-zero
//   ovr_o     sticky: a trigger was dropped while busy
interface adc_sample_sequencer_if;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ZERO_W = 4;

    logic              en_i;
    logic              start_i;
    logic              clr_ovr_i;
    logic              data_in_i;
    logic              sclk_o;
    logic              cs_o;
    logic [DATA_W-1:0] dato_o;
    logic [ZERO_W-1:0] zeros_o;
    logic              listo_o;
    logic              busy_o;
    logic              err_z_o;
    logic              ovr_o;

    modport slave (
        input  en_i, start_i, clr_ovr_i, data_in_i,
        output sclk_o, cs_o, dato_o, zeros_o, listo_o, busy_o, err_z_o, ovr_o
    );

    modport master (
        output en_i, start_i, clr_ovr_i, data_in_i,
        input  sclk_o, cs_o, dato_o, zeros_o, listo_o, busy_o, err_z_o, ovr_o
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// Sequences serial ADC conversions: paces triggers (periodic or single-shot),
// drives CS/SCLK, shifts in 16 bits MSB first (4 leading zeros + 12 data) and
// presents the word with a one-cycle listo strobe. Flags dropped triggers (ovr)
// and non-zero leading bits (err_z).
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   adc_sample_sequencer_if.slave (control, serial pins, results)
module adc_sample_sequencer #(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CS_SETUP      = 2,
    parameter int unsigned CS_HOLD       = 2,
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_sample_sequencer_if.slave bus
);
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_W      = 5;
    localparam int unsigned CNT_MAX    = (CLK_DIV > CS_SETUP)
                                         ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                         : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic                    listo_q, listo_d;
    logic                    err_z_q, err_z_d;
    logic                    ovr_q, ovr_d;
    logic [11:0]             dato_q, dato_d;
    logic [3:0]              zeros_q, zeros_d;
    logic                    tc_c;
    logic                    trig_c;

    // Sample-period timer; held at zero while periodic sampling is off.
    assign tc_c   = bus.en_i && (timer_q == TMR_W'(SAMPLE_PERIOD - 1));
    assign trig_c = bus.start_i | tc_c;

    always_comb begin
        timer_d = timer_q;
        if (!bus.en_i || tc_c) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            timer_q   <= '0;
            sclk_q    <= 1'b1;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            listo_q   <= 1'b0;
            err_z_q   <= 1'b0;
            ovr_q     <= 1'b0;
            dato_q    <= '0;
            zeros_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            timer_q   <= timer_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            listo_q   <= listo_d;
            err_z_q   <= err_z_d;
            ovr_q     <= ovr_d;
            dato_q    <= dato_d;
            zeros_q   <= zeros_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        listo_d   = 1'b0;
        err_z_d   = err_z_q;
        dato_d    = dato_q;
        zeros_d   = zeros_q;
        ovr_d     = ovr_q;

        // A drop in the same cycle as a clear must leave ovr set.
        if (bus.clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (trig_c && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig_c) begin
                    state_d   = S_SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK edge: capture the bit the ADC presented.
                        sclk_d    = 1'b1;
                        sr_d      = {sr_q[FRAME_BITS-2:0], bus.data_in_i};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else if (bit_cnt_q == BIT_W'(FRAME_BITS)) begin
                        state_d = S_HOLD;
                        cs_d    = 1'b1;
                        dato_d  = sr_q[11:0];
                        zeros_d = sr_q[15:12];
                        err_z_d = (sr_q[15:12] != 4'h0);
                        listo_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sclk_o  = sclk_q;
    assign bus.cs_o    = cs_q;
    assign bus.dato_o  = dato_q;
    assign bus.zeros_o = zeros_q;
    assign bus.listo_o = listo_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_z_o = err_z_q;
    assign bus.ovr_o   = ovr_q;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: single-shot frames, leading-bit
// error, overrun set/clear, periodic triggering, coincident start/tc and
// mid-frame reset. A small ADC model presents word bits on SCLK rises.
module tb_adc_sample_sequencer;
    logic clk;
    logic rst;
    logic [15:0] adc_word;
    int          rise_cnt;
    int          listo_cnt;
    logic        sclk_prev;
    int          n_cmp;
    int          n_bad;
    int          lc;

    adc_sample_sequencer_if bus ();

    adc_sample_sequencer #(
        .CLK_DIV       (2),
        .CS_SETUP      (2),
        .CS_HOLD       (2),
        .SAMPLE_PERIOD (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model: bit for the next SCLK rise is presented after each rise; also counts listo strobes.
    always @(negedge clk) begin
        if (bus.cs_o) begin
            rise_cnt = 0;
        end else if (bus.sclk_o && !sclk_prev) begin
            rise_cnt = rise_cnt + 1;
        end
        sclk_prev = bus.sclk_o;
        bus.data_in_i = (rise_cnt < 16) ? adc_word[4'(15 - rise_cnt)] : 1'b0;
        if (bus.listo_o) listo_cnt = listo_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rise_cnt      = 0;
        listo_cnt     = 0;
        sclk_prev     = 1'b1;
        adc_word      = 16'h0000;
        rst           = 1'b0;
        bus.en_i      = 1'b0;
        bus.start_i   = 1'b0;
        bus.clr_ovr_i = 1'b0;

        // Reset state
        step(3);
        chk("rst_cs",    32'(bus.cs_o),    32'd1);
        chk("rst_sclk",  32'(bus.sclk_o),  32'd1);
        chk("rst_dato",  32'(bus.dato_o),  32'd0);
        chk("rst_zeros", 32'(bus.zeros_o), 32'd0);
        chk("rst_listo", 32'(bus.listo_o), 32'd0);
        chk("rst_busy",  32'(bus.busy_o),  32'd0);
        chk("rst_errz",  32'(bus.err_z_o), 32'd0);
        chk("rst_ovr",   32'(bus.ovr_o),   32'd0);
        rst = 1'b1;
        step(2);

        // Test 1: single shot, word 0x0A5A
        adc_word    = 16'h0A5A;
        bus.start_i = 1'b1;                         // cycle A
        step(1);
        bus.start_i = 1'b0;                         // A+1
        chk("t1_cs_low",   32'(bus.cs_o),   32'd0);
        chk("t1_busy",     32'(bus.busy_o), 32'd1);
        chk("t1_sclk_su",  32'(bus.sclk_o), 32'd1);
        step(2);                                    // A+3
        chk("t1_sclk_lo",  32'(bus.sclk_o), 32'd0);
        step(63);                                   // A+66
        chk("t1_rises",    32'(rise_cnt),   32'd16);
        chk("t1_nolisto",  32'(bus.listo_o), 32'd0);
        step(1);                                    // A+67
        chk("t1_listo",    32'(bus.listo_o), 32'd1);
        chk("t1_dato",     32'(bus.dato_o),  32'hA5A);
        chk("t1_zeros",    32'(bus.zeros_o), 32'h0);
        chk("t1_errz",     32'(bus.err_z_o), 32'd0);
        chk("t1_cs_hi",    32'(bus.cs_o),    32'd1);
        chk("t1_busy_h",   32'(bus.busy_o),  32'd1);
        step(1);                                    // A+68
        chk("t1_listo_1c", 32'(bus.listo_o), 32'd0);
        chk("t1_busy_h2",  32'(bus.busy_o),  32'd1);
        step(1);                                    // A+69
        chk("t1_idle",     32'(bus.busy_o),  32'd0);
        chk("t1_ovr",      32'(bus.ovr_o),   32'd0);

        // Test 2: leading bits 0101, data 0xFFF
        step(2);
        chk("t2_dato_hold", 32'(bus.dato_o), 32'hA5A);
        adc_word    = 16'h5FFF;
        bus.start_i = 1'b1;
        step(1);
        bus.start_i = 1'b0;
        step(66);                                   // B+67
        chk("t2_listo", 32'(bus.listo_o), 32'd1);
        chk("t2_dato",  32'(bus.dato_o),  32'hFFF);
        chk("t2_zeros", 32'(bus.zeros_o), 32'h5);
        chk("t2_errz",  32'(bus.err_z_o), 32'd1);
        step(2);
        chk("t2_idle",  32'(bus.busy_o),  32'd0);

        // Test 4: start mid-frame sets ovr, frame unaffected, clr_ovr clears
        step(2);
        adc_word    = 16'h0123;
        lc          = listo_cnt;
        bus.start_i = 1'b1;                         // A
        step(1);
        bus.start_i = 1'b0;
        step(29);                                   // A+30
        bus.start_i = 1'b1;
        step(1);                                    // A+31
        bus.start_i = 1'b0;
        chk("t4_ovr_set", 32'(bus.ovr_o),  32'd1);
        chk("t4_busy",    32'(bus.busy_o), 32'd1);
        step(36);                                   // A+67
        chk("t4_listo",   32'(bus.listo_o), 32'd1);
        chk("t4_dato",    32'(bus.dato_o),  32'h123);
        chk("t4_errz",    32'(bus.err_z_o), 32'd0);
        step(2);
        chk("t4_idle",    32'(bus.busy_o), 32'd0);
        chk("t4_ovr_stk", 32'(bus.ovr_o),  32'd1);
        chk("t4_one_lst", 32'(listo_cnt - lc), 32'd1);
        bus.clr_ovr_i = 1'b1;
        step(1);
        bus.clr_ovr_i = 1'b0;
        chk("t4_ovr_clr", 32'(bus.ovr_o), 32'd0);

        // Trigger in A+1 is dropped; simultaneous clr_ovr loses to the set
        step(2);
        lc          = listo_cnt;
        bus.start_i = 1'b1;                         // A
        step(1);
        bus.clr_ovr_i = 1'b1;                       // A+1, start still high
        step(1);                                    // A+2
        bus.start_i   = 1'b0;
        bus.clr_ovr_i = 1'b0;
        chk("t4b_ovr_win", 32'(bus.ovr_o),  32'd1);
        chk("t4b_busy",    32'(bus.busy_o), 32'd1);
        step(67);                                   // A+69
        chk("t4b_idle",    32'(bus.busy_o), 32'd0);
        chk("t4b_one_lst", 32'(listo_cnt - lc), 32'd1);
        bus.clr_ovr_i = 1'b1;
        step(1);
        bus.clr_ovr_i = 1'b0;
        chk("t4b_ovr_clr", 32'(bus.ovr_o), 32'd0);

        // Test 3 + 5: periodic frames every 100 cycles, then start coincident with tc
        step(2);
        adc_word = 16'h0ABC;
        bus.en_i = 1'b1;                            // E, timer at 0
        step(99);                                   // E+99 (tc)
        chk("t3_cs_pre1",  32'(bus.cs_o),   32'd1);
        chk("t3_idle1",    32'(bus.busy_o), 32'd0);
        step(1);                                    // E+100
        lc = listo_cnt;
        chk("t3_cs_f1",    32'(bus.cs_o),   32'd0);
        chk("t3_busy1",    32'(bus.busy_o), 32'd1);
        step(99);                                   // E+199
        chk("t3_cs_pre2",  32'(bus.cs_o),   32'd1);
        step(1);                                    // E+200
        chk("t3_cs_f2",    32'(bus.cs_o),   32'd0);
        chk("t3_ovr",      32'(bus.ovr_o),  32'd0);
        chk("t3_lst_f1",   32'(listo_cnt - lc), 32'd1);
        step(99);                                   // E+299 (tc)
        bus.start_i = 1'b1;
        chk("t5_idle",     32'(bus.busy_o), 32'd0);
        step(1);                                    // E+300
        bus.start_i = 1'b0;
        bus.en_i    = 1'b0;
        chk("t5_cs",       32'(bus.cs_o),   32'd0);
        chk("t5_ovr",      32'(bus.ovr_o),  32'd0);
        step(69);                                   // E+369
        chk("t5_idle2",    32'(bus.busy_o), 32'd0);
        chk("t5_lst_cnt",  32'(listo_cnt - lc), 32'd3);
        chk("t5_dato",     32'(bus.dato_o), 32'hABC);
        chk("t5_ovr2",     32'(bus.ovr_o),  32'd0);
        step(200);
        chk("t3_en_off",   32'(listo_cnt - lc), 32'd3);
        chk("t3_busy_off", 32'(bus.busy_o), 32'd0);

        // Test 6: reset at A+40 aborts the frame
        step(2);
        adc_word    = 16'hFFFF;
        lc          = listo_cnt;
        bus.start_i = 1'b1;                         // A
        step(1);
        bus.start_i = 1'b0;
        step(39);                                   // A+40
        chk("t6_busy_pre", 32'(bus.busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_cs",    32'(bus.cs_o),    32'd1);
        chk("t6_sclk",  32'(bus.sclk_o),  32'd1);
        chk("t6_busy",  32'(bus.busy_o),  32'd0);
        chk("t6_dato",  32'(bus.dato_o),  32'd0);
        chk("t6_listo", 32'(bus.listo_o), 32'd0);
        step(3);
        rst = 1'b1;
        step(80);
        chk("t6_nolisto", 32'(listo_cnt - lc), 32'd0);
        chk("t6_idle",    32'(bus.busy_o), 32'd0);
        chk("t6_dato2",   32'(bus.dato_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
